// File: rtl/lsu_mem_stage.sv
// Load/store memory stage: issues one data-memory access at a time, stalls the
// pipeline until acknowledged, and handles lane masking, store replication and load extension.
module lsu_mem_stage #(
   parameter int DataWidth     = 32,
   parameter int AddrWidth     = 32,
   parameter int TimeoutCycles = 255
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid,
   input  logic                     load,
   input  logic                     store,
   input  logic [2:0]               fun3,
   input  logic [AddrWidth-1:0]     alu_out_address,
   input  logic [DataWidth-1:0]     operand_b,
   input  logic                     data_valid,
   input  logic [DataWidth-1:0]     wrap_load_in,
   output logic                     request,
   output logic                     we_re,
   output logic [AddrWidth-1:0]     addr,
   output logic [DataWidth/8-1:0]   mask,
   output logic [DataWidth-1:0]     store_data_out,
   output logic [DataWidth-1:0]     wrap_load_out,
   output logic                     stall,
   output logic                     access_done,
   output logic                     misaligned,
   output logic                     timeout_err
);

   localparam int Lanes = DataWidth / 8;
   localparam int OffW  = $clog2(Lanes);
   localparam int CntW  = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   // D and WU only exist on a 64-bit bus; 111 never exists.
   function automatic logic size_legal(input logic [2:0] f3);
      logic ok;
      case (f3)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
         3'b011, 3'b110:                         ok = (DataWidth == 64);
         default:                                ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [OffW-1:0] align_mask(input logic [1:0] lg);
      logic [2:0] m;
      case (lg)
         2'd0:    m = 3'b000;
         2'd1:    m = 3'b001;
         2'd2:    m = 3'b011;
         default: m = 3'b111;
      endcase
      return m[OffW-1:0];
   endfunction

   function automatic logic [Lanes-1:0] lane_mask(input logic [OffW-1:0] off, input logic [1:0] lg);
      logic [Lanes-1:0] m;
      int sz;
      sz = int'(8'd1 << lg);
      for (int i = 0; i < Lanes; i++) begin
         m[i] = (i >= int'(off)) && (i < int'(off) + sz);
      end
      return m;
   endfunction

   function automatic logic [DataWidth-1:0] replicate(input logic [DataWidth-1:0] d, input logic [1:0] lg);
      logic [DataWidth-1:0] r;
      int src;
      for (int i = 0; i < Lanes; i++) begin
         src = i & (int'(8'd1 << lg) - 1);
         r[i*8 +: 8] = d[src*8 +: 8];
      end
      return r;
   endfunction

   // Align the addressed bytes to bit 0, then sign- or zero-fill above the access size.
   function automatic logic [DataWidth-1:0] extend(input logic [DataWidth-1:0] raw,
                                                   input logic [OffW-1:0]      off,
                                                   input logic [1:0]           lg,
                                                   input logic                 uns);
      logic [DataWidth-1:0] sh;
      logic [DataWidth-1:0] r;
      logic                 sgn;
      int                   nbits;
      sh    = raw >> {off, 3'b000};
      nbits = int'(8'd8 << lg);
      if (nbits > DataWidth) begin
         nbits = DataWidth;
      end else begin
         nbits = nbits;
      end
      sgn = ~uns & sh[nbits-1];
      for (int j = 0; j < DataWidth; j++) begin
         r[j] = (j < nbits) ? sh[j] : sgn;
      end
      return r;
   endfunction

   state_e                 state_q, state_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [Lanes-1:0]       mask_q, mask_d;
   logic [DataWidth-1:0]   sd_q, sd_d;
   logic [DataWidth-1:0]   wlo_q, wlo_d;
   logic                   we_q, we_d;
   logic                   req_q, req_d;
   logic                   done_q, done_d;
   logic                   tmo_q, tmo_d;
   logic                   mis_q, mis_d;
   logic [2:0]             f3_q, f3_d;
   logic [OffW-1:0]        off_q, off_d;

   logic [OffW-1:0]        off_s;
   logic                   op_s;
   logic                   legal_s;
   logic                   accept_s;
   logic                   misal_s;

   assign off_s    = alu_out_address[OffW-1:0];
   assign op_s     = valid & (load ^ store);
   assign legal_s  = size_legal(fun3) && ((off_s & align_mask(fun3[1:0])) == '0);
   assign accept_s = (state_q == IDLE) & op_s & legal_s;
   assign misal_s  = (state_q == IDLE) & op_s & ~legal_s;

   // Next-state and datapath capture for the access FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      sd_d    = sd_q;
      wlo_d   = wlo_q;
      we_d    = we_q;
      req_d   = req_q;
      f3_d    = f3_q;
      off_d   = off_q;
      done_d  = 1'b0;
      tmo_d   = 1'b0;
      mis_d   = misal_s;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = BUSY;
               req_d   = 1'b1;
               cnt_d   = '0;
               addr_d  = {alu_out_address[AddrWidth-1:OffW], {OffW{1'b0}}};
               mask_d  = lane_mask(off_s, fun3[1:0]);
               sd_d    = replicate(operand_b, fun3[1:0]);
               we_d    = store;
               f3_d    = fun3;
               off_d   = off_s;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            // An ack in the final counted cycle still completes normally.
            if (data_valid) begin
               state_d = RESP;
               req_d   = 1'b0;
               done_d  = 1'b1;
               if (!we_q) begin
                  wlo_d = extend(wrap_load_in, off_q, f3_q[1:0], f3_q[2]);
               end else begin
                  wlo_d = wlo_q;
               end
            end else if (cnt_q == CntLast) begin
               state_d = RESP;
               req_d   = 1'b0;
               tmo_d   = 1'b1;
               wlo_d   = '0;
            end else begin
               cnt_d = cnt_q + CntW'(1'b1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         mask_q  <= '0;
         sd_q    <= '0;
         wlo_q   <= '0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
         mis_q   <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
         sd_q    <= sd_d;
         wlo_q   <= wlo_d;
         we_q    <= we_d;
         req_q   <= req_d;
         done_q  <= done_d;
         tmo_q   <= tmo_d;
         mis_q   <= mis_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
      end
   end

   // Stall must rise in the accept cycle itself, so it cannot wait for the state register.
   assign stall          = rst & ((state_q == BUSY) | accept_s);
   assign request        = req_q;
   assign we_re          = we_q;
   assign addr           = addr_q;
   assign mask           = mask_q;
   assign store_data_out = sd_q;
   assign wrap_load_out  = wlo_q;
   assign access_done    = done_q;
   assign timeout_err    = tmo_q;
   assign misaligned     = mis_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: hand-built vector table, randomized ops against a
// byte-level reference model, plus reset-during-access sequence.
module tb_lsu_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid, load, store, data_valid;
   logic [2:0]  fun3;
   logic [31:0] alu_out_address, operand_b, wrap_load_in;
   logic        request, we_re, stall, access_done, misaligned, timeout_err;
   logic [31:0] addr, store_data_out, wrap_load_out;
   logic [3:0]  mask;

   int checks   = 0;
   int failures = 0;

   lsu_mem_stage #(.DataWidth(32), .AddrWidth(32), .TimeoutCycles(8)) dut (
      .clk(clk), .rst(rst), .valid(valid), .load(load), .store(store), .fun3(fun3),
      .alu_out_address(alu_out_address), .operand_b(operand_b),
      .data_valid(data_valid), .wrap_load_in(wrap_load_in),
      .request(request), .we_re(we_re), .addr(addr), .mask(mask),
      .store_data_out(store_data_out), .wrap_load_out(wrap_load_out),
      .stall(stall), .access_done(access_done), .misaligned(misaligned),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // kind: 0 = accepted, 1 = misaligned, 2 = ignored. n = cycle of data_valid (outside 1..8 -> timeout).
   typedef struct {
      logic        ld, st;
      logic [2:0]  f3;
      logic [31:0] a, ob, rd;
      int          n;
      int          kind;
      logic [31:0] eaddr;
      logic [3:0]  emask;
      logic [31:0] esd;
      logic [31:0] ewlo;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Reference model: byte-level arithmetic on the access rules.
   function automatic vec_t make_vec(input logic ld, st, input logic [2:0] f3,
                                     input logic [31:0] a, ob, rd, input int n,
                                     input logic [31:0] prev_wlo);
      vec_t   v;
      int     size, off;
      longint val, span;
      logic [31:0] erd;
      bit     tmo;
      v.ld = ld; v.st = st; v.f3 = f3; v.a = a; v.ob = ob; v.rd = rd; v.n = n;
      case (f3)
         3'd0, 3'd4: size = 1;
         3'd1, 3'd5: size = 2;
         3'd2:       size = 4;
         default:    size = 0;
      endcase
      off = int'(a % 32'd4);
      if (ld == st) v.kind = 2;
      else if (size == 0 || (off % size) != 0) v.kind = 1;
      else v.kind = 0;
      if (size == 0) size = 1;
      v.eaddr = a - 32'(off);
      v.emask = 4'b0000;
      v.esd   = 32'h0;
      for (int k = 0; k < 4; k++) begin
         v.emask[k] = (k >= off) && (k < off + size);
         v.esd = v.esd | (((ob >> (8 * (k % size))) & 32'hFF) << (8 * k));
      end
      span = 64'sd1 << (8 * size);
      val  = (longint'(rd) >> (8 * off)) % span;
      if (!f3[2] && val >= span / 2) val = val - span;
      erd = 32'(val);
      tmo = !(n >= 1 && n <= 8);
      if (v.kind != 0) v.ewlo = prev_wlo;
      else if (tmo)    v.ewlo = 32'h0;
      else if (ld)     v.ewlo = erd;
      else             v.ewlo = prev_wlo;
      return v;
   endfunction

   task automatic do_and_check(input vec_t v, input string tag);
      int req_cnt = 0, stall_cnt = 0, done_cnt = 0, tmo_cnt = 0, mis_cnt = 0;
      int mis_cyc = -1, resp_cyc = -1;
      int exp_req, exp_tmo;
      logic [31:0] s_addr = '0, s_sd = '0, wlo_resp = '0;
      logic [3:0]  s_mask = '0;
      logic        s_we = 1'b0, stable = 1'b1, prev_stall, resp_seen = 1'b0;

      @(negedge clk);
      valid = 1'b1; load = v.ld; store = v.st; fun3 = v.f3;
      alu_out_address = v.a; operand_b = v.ob; data_valid = 1'b0; wrap_load_in = $urandom;
      #1;
      if (stall) stall_cnt++;
      if (request) req_cnt++;
      prev_stall = stall;
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         valid        = prev_stall;
         data_valid   = (c == v.n) || resp_seen;
         wrap_load_in = (c == v.n) ? v.rd : $urandom;
         #1;
         if (request) begin
            if (req_cnt == 0) begin
               s_addr = addr; s_mask = mask; s_we = we_re; s_sd = store_data_out;
            end else if (addr !== s_addr || mask !== s_mask || we_re !== s_we || store_data_out !== s_sd) begin
               stable = 1'b0;
            end
            req_cnt++;
         end
         if (stall) stall_cnt++;
         if (access_done || timeout_err) begin
            if (!resp_seen) begin
               resp_cyc = c;
               wlo_resp = wrap_load_out;
            end
            resp_seen = 1'b1;
         end
         if (access_done) done_cnt++;
         if (timeout_err) tmo_cnt++;
         if (misaligned) begin
            if (mis_cnt == 0) mis_cyc = c;
            mis_cnt++;
         end
         prev_stall = stall;
      end
      @(negedge clk);
      valid = 1'b0; data_valid = 1'b0;

      exp_tmo = (v.kind == 0 && !(v.n >= 1 && v.n <= 8)) ? 1 : 0;
      exp_req = (v.kind != 0) ? 0 : (exp_tmo ? 8 : v.n);
      chk({tag, " req_cycles"}, req_cnt, exp_req);
      chk({tag, " stall_cycles"}, stall_cnt, (v.kind == 0) ? exp_req + 1 : 0);
      chk({tag, " done_pulses"}, done_cnt, (v.kind == 0 && exp_tmo == 0) ? 1 : 0);
      chk({tag, " timeout_pulses"}, tmo_cnt, exp_tmo);
      chk({tag, " misaligned_pulses"}, mis_cnt, (v.kind == 1) ? 1 : 0);
      if (v.kind == 1) chk({tag, " misaligned_cycle"}, mis_cyc, 1);
      if (v.kind == 0) begin
         chk({tag, " addr"}, s_addr, v.eaddr);
         chk({tag, " mask"}, s_mask, v.emask);
         chk({tag, " we_re"}, s_we, v.st);
         chk({tag, " busy_stable"}, stable, 1'b1);
         chk({tag, " resp_cycle"}, resp_cyc, exp_req + 1);
         chk({tag, " wlo_in_resp"}, wlo_resp, v.ewlo);
         if (v.st) chk({tag, " store_data"}, s_sd, v.esd);
      end
      chk({tag, " wlo_held"}, wrap_load_out, v.ewlo);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[14];
      vec_t v;
      logic [31:0] exp_wlo;
      int hits;

      tv[0]  = '{1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_1234, 3, 0, 32'h0000_1000, 4'b1000, 32'h0,         32'hFFFF_FF80};
      tv[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,         1, 0, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80};
      tv[2]  = '{1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0,         32'h8001_0000, 2, 0, 32'h0000_4000, 4'b1100, 32'h0,         32'h0000_8001};
      tv[3]  = '{1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0,         32'h0,         1, 1, 32'h0,         4'b0000, 32'h0,         32'h0000_8001};
      tv[4]  = '{1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0,         32'h0,         1, 1, 32'h0,         4'b0000, 32'h0,         32'h0000_8001};
      tv[5]  = '{1'b1, 1'b1, 3'b010, 32'h0000_B000, 32'h0,         32'h0,         1, 2, 32'h0,         4'b0000, 32'h0,         32'h0000_8001};
      tv[6]  = '{1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0,         32'h0,         0, 0, 32'h0000_5000, 4'b1111, 32'h0,         32'h0};
      tv[7]  = '{1'b0, 1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 32'h0,         2, 0, 32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
      tv[8]  = '{1'b1, 1'b0, 3'b001, 32'h0000_7002, 32'h0,         32'h8001_7FFF, 4, 0, 32'h0000_7000, 4'b1100, 32'h0,         32'hFFFF_8001};
      tv[9]  = '{1'b1, 1'b0, 3'b110, 32'h0000_7000, 32'h0,         32'h0,         1, 1, 32'h0,         4'b0000, 32'h0,         32'hFFFF_8001};
      tv[10] = '{1'b1, 1'b0, 3'b111, 32'h0000_7000, 32'h0,         32'h0,         1, 1, 32'h0,         4'b0000, 32'h0,         32'hFFFF_8001};
      tv[11] = '{1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'h0,         32'hDEAD_BEEF, 8, 0, 32'h0000_8000, 4'b1111, 32'h0,         32'hDEAD_BEEF};
      tv[12] = '{1'b0, 1'b1, 3'b010, 32'h0000_9004, 32'hCAFE_F00D, 32'h0,         9, 0, 32'h0000_9004, 4'b1111, 32'hCAFE_F00D, 32'h0};
      tv[13] = '{1'b1, 1'b0, 3'b100, 32'h0000_A002, 32'h0,         32'h1234_5678, 1, 0, 32'h0000_A000, 4'b0100, 32'h0,         32'h0000_0034};

      rst = 1'b0; valid = 1'b0; load = 1'b0; store = 1'b0; fun3 = 3'b000;
      alu_out_address = '0; operand_b = '0; data_valid = 1'b0; wrap_load_in = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset request", request, 1'b0);
      chk("reset stall", stall, 1'b0);
      chk("reset outputs", {we_re, addr, mask, store_data_out, wrap_load_out, access_done, misaligned, timeout_err}, '0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 14; i++) begin
         do_and_check(tv[i], $sformatf("vec%0d", i));
      end

      exp_wlo = tv[13].ewlo;
      for (int i = 0; i < 60; i++) begin
         int r;
         logic ld, st;
         r  = $urandom_range(0, 9);
         ld = (r == 0) ? 1'b1 : r[0];
         st = (r == 0) ? 1'b1 : ~r[0];
         v  = make_vec(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                       $urandom_range(0, 9), exp_wlo);
         do_and_check(v, $sformatf("rnd%0d", i));
         exp_wlo = v.ewlo;
      end

      // Reset asserted in the middle of a BUSY access.
      @(negedge clk);
      valid = 1'b1; load = 1'b1; store = 1'b0; fun3 = 3'b010;
      alu_out_address = 32'h0000_C004; data_valid = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mid pre_request", request, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk("rst_mid request", request, 1'b0);
      chk("rst_mid stall", stall, 1'b0);
      chk("rst_mid addr", addr, 32'h0);
      @(negedge clk);
      rst = 1'b1; valid = 1'b0; data_valid = 1'b1;
      hits = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         if (request || access_done || timeout_err || stall) hits++;
      end
      data_valid = 1'b0;
      chk("rst_mid no_activity_after", hits, 0);
      chk("rst_mid wlo", wrap_load_out, 32'h0);

      v = make_vec(1'b1, 1'b0, 3'b010, 32'h0000_D000, 32'h0, 32'h0123_4567, 2, 32'h0);
      do_and_check(v, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Parametrised load/store memory stage for the rv32i-sv pipeline, sitting between execute and writeback. It issues one data-memory access at a time, holds the pipeline with `stall` until memory acknowledges with `data_valid`, and applies byte-lane masking, store-data replication and load sign/zero extension over a configurable data width. It also adds what the single-cycle stage lacked: misalignment detection, a response timeout and registered load results.

## Interface
- `DataWidth`, 32: data bus width; legal values are 32 or 64. Lanes = DataWidth/8.
- `AddrWidth`, 32: address width.
- `TimeoutCycles`, 255: maximum number of BUSY cycles before the access is abandoned; must be ≥1.
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous, active-low.
- `valid` in 1: execute-stage instruction valid.
- `load` / `store` in 1: access type from decode.
- `fun3` in 3: instruction[14:12].
- `alu_out_address` in AddrWidth: effective byte address.
- `operand_b` in DataWidth: store source data.
- `data_valid` in 1: memory response/ack; for loads, qualifies `wrap_load_in`.
- `wrap_load_in` in DataWidth: raw memory read word.
- `request` out 1: memory request, held high for the whole BUSY state.
- `we_re` out 1: 1 = write, 0 = read; meaningful only while `request` is high.
- `addr` out AddrWidth: address with the low log2(Lanes) bits cleared.
- `mask` out Lanes: active byte lanes.
- `store_data_out` out DataWidth: replicated store data.
- `wrap_load_out` out DataWidth: registered, extended load result.
- `stall` out 1: freezes the upstream pipeline.
- `access_done` out 1: one-cycle completion pulse.
- `misaligned` out 1: one-cycle error pulse.
- `timeout_err` out 1: one-cycle error pulse.

## Operation
- **FSM states**
  - IDLE: accept an operation when `valid & (load ^ store)` and the address is aligned for its size. On accept:
    - capture `addr`, `mask`, `store_data_out`, `we_re=store`, `fun3` and byte offset;
    - assert `stall` combinationally in the same cycle;
    - go to BUSY.
  - IDLE, misaligned operation: no request; register a `misaligned` pulse for the next cycle.
  - IDLE, `load & store` both high: operation ignored; no request and no flag.
  - BUSY: `request=1`, `stall=1`, timeout counter increments each cycle.
    - `data_valid=1` → go to RESP. For a load, register the extended result into `wrap_load_out`.
    - Counter reaches TimeoutCycles with no `data_valid` → go to RESP with the error flagged.
  - RESP (one cycle): `stall=0` and `request=0`. Pulse `access_done` (normal completion) or `timeout_err` (timeout). Never accepts an operation, because the completed instruction is still presented that cycle. Goes to IDLE.
- **Sizes (`fun3`)**
  - 000 B, 001 H, 010 W (sign-extended loads).
  - 100 BU, 101 HU (zero-extended loads).
  - 011 D and 110 WU are legal only when DataWidth=64; otherwise they are treated as misaligned.
- **Alignment**: H needs offset[0]=0; W needs offset[1:0]=0; D needs offset[2:0]=0.
- **Mask**: contiguous size-wide lane field starting at lane = offset, for both loads and stores.
- **Store data**: the low size-bytes of `operand_b` are replicated across all lanes.
- **Load data**: shift `wrap_load_in` right by offset×8, truncate to the size, then sign- or zero-extend to DataWidth.
- On timeout, `wrap_load_out` is set to 0.

## Timing
- **Reset values**: all outputs 0, state IDLE, counter 0. Asserting `rst` mid-access drops `request` and `stall` immediately; no `access_done` or `timeout_err` is produced.
- **Latency**
  - Accept at cycle 0; `request` is high from cycle 1.
  - If `data_valid` is first seen in cycle N, RESP is cycle N+1: `wrap_load_out` is valid and `access_done=1` there.
- **Stall**: `stall` is high from cycle 0 through cycle N inclusive.
- **Outputs while BUSY**: `addr`, `mask`, `we_re` and `store_data_out` are held stable for the whole BUSY state.
- **Spurious ack**: `data_valid` outside BUSY is ignored.
- **Error pulse timing**: `misaligned` is high for exactly one cycle, the cycle after detection.
- **Timeout count**: `request` stays high for exactly TimeoutCycles cycles, then RESP.
- **Held result**: `wrap_load_out` holds its value until the next completed load or timeout.

## Test plan
- **LB**: LB at 0x1003; memory returns 0x80FF_1234 with `data_valid` 3 cycles after `request` rises.
  - During the access: `addr`=0x1000, `mask`=1000, `we_re`=0, `stall` high for 4 cycles.
  - In RESP: `wrap_load_out`=0xFFFF_FF80, then `access_done` pulses.
- **SH**: SH at 0x2002 with `operand_b`=0x1234_ABCD, `data_valid` after 1 cycle. Expect `store_data_out`=0xABCD_ABCD, `mask`=1100, `we_re`=1, a single `access_done` pulse, and `wrap_load_out` unchanged.
- **LHU**: LHU at 0x4002 returning 0x8001_0000. Expect `wrap_load_out`=0x0000_8001.
- **Misaligned LW**: LW at 0x3001. Expect `request` never high, `stall`=0, `misaligned` pulse one cycle later. Also LD with DataWidth=32 gives the same response.
- **Timeout**: TimeoutCycles=8, `data_valid` never asserted. Expect `request` high for exactly 8 cycles, then `timeout_err` pulse, `wrap_load_out`=0, `stall` released.
- **Illegal and reset cases**
  - `load` and `store` both high: no request and no flag.
  - `rst` low during BUSY: `request`, `stall` and `addr` go to 0 asynchronously; after release the FSM is in IDLE with no done pulse.
